// File: rtl/alu_sequencer.sv
// Runs up to four ops from op_list through an external ALU, one slot at a time,
// optionally chaining each result into the next slot's A operand.
module alu_sequencer #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  sw,
    input  logic [7:0]  op_list,
    input  logic [1:0]  op_count,
    input  logic        chain,
    input  logic [3:0]  alu_rezult,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_operation,
    output logic        alu_enable,
    output logic [15:0] result_bus,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // WAIT ends when the counter reaches zero, so it is loaded with latency-1.
    localparam logic [1:0] LAT_LOAD = 2'(ALU_LATENCY - 1);

    state_t          state, state_nxt;
    logic [1:0]      idx;
    logic [1:0]      lat_cnt;
    logic [1:0]      cnt_q;
    logic [3:0]      a_q, b_q;
    logic [3:0][1:0] ops_q;
    logic            chain_q;
    logic [3:0][3:0] res_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            lat_cnt <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ops_q   <= '0;
            chain_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= sw[3:0];
                        b_q     <= sw[7:4];
                        ops_q   <= op_list;
                        cnt_q   <= op_count;
                        chain_q <= chain;
                        res_q   <= '0;
                        idx     <= '0;
                    end
                end
                ISSUE: lat_cnt <= LAT_LOAD;
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        res_q[idx] <= alu_rezult;
                        if (idx != cnt_q)
                            idx <= idx + 2'd1;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        alu_a         = '0;
        alu_b         = '0;
        alu_operation = '0;
        alu_enable    = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == 2'd0) state_nxt = (idx == cnt_q) ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Operands stay on the bus for the whole ISSUE+WAIT window; reset blanks everything.
        if (reset_n && (state == ISSUE || state == WAIT)) begin
            alu_a         = (idx == 2'd0 || !chain_q) ? a_q : res_q[idx - 2'd1];
            alu_b         = b_q;
            alu_operation = ops_q[idx];
            alu_enable    = (state == ISSUE);
        end
        if (reset_n) begin
            busy = (state != IDLE);
            done = (state == DONE);
        end
    end

    assign result_bus = res_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (latency 1 and 3) share stimulus; a
// cycle-timed model predicts every output, plus directed literal checks.
module tb_alu_sequencer;
    logic        clock, reset_n, start, chain;
    logic [7:0]  sw, op_list;
    logic [1:0]  op_count;
    logic [3:0]  alu_rezult [2];
    logic [3:0]  alu_a [2];
    logic [3:0]  alu_b [2];
    logic [1:0]  alu_operation [2];
    logic        alu_enable [2];
    logic        busy [2];
    logic        done [2];
    logic [15:0] result_bus [2];

    int ncmp = 0;
    int nfail = 0;

    alu_sequencer #(.ALU_LATENCY(1)) dut_l1 (
        .clock(clock), .reset_n(reset_n), .start(start), .sw(sw), .op_list(op_list),
        .op_count(op_count), .chain(chain), .alu_rezult(alu_rezult[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_operation(alu_operation[0]),
        .alu_enable(alu_enable[0]), .result_bus(result_bus[0]), .busy(busy[0]), .done(done[0])
    );

    alu_sequencer #(.ALU_LATENCY(3)) dut_l3 (
        .clock(clock), .reset_n(reset_n), .start(start), .sw(sw), .op_list(op_list),
        .op_count(op_count), .chain(chain), .alu_rezult(alu_rezult[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_operation(alu_operation[1]),
        .alu_enable(alu_enable[1]), .result_bus(result_bus[1]), .busy(busy[1]), .done(done[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Datapath stand-in: the answer is only presented on the exact sample cycle,
    // otherwise its complement is driven so a mistimed capture is visible.
    logic [3:0] pd [2][4];
    logic       pv [2][4];
    logic [3:0] last [2];
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                for (int j = 0; j < 4; j++) pv[i][j] <= 1'b0;
                last[i] <= 4'h0;
            end else begin
                pv[i][0] <= alu_enable[i];
                pd[i][0] <= alu_f(alu_operation[i], alu_a[i], alu_b[i]);
                for (int j = 1; j < 4; j++) begin
                    pv[i][j] <= pv[i][j-1];
                    pd[i][j] <= pd[i][j-1];
                end
                if (alu_enable[i]) last[i] <= alu_f(alu_operation[i], alu_a[i], alu_b[i]);
            end
        end
    end
    assign alu_rezult[0] = pv[0][0] ? pd[0][0] : ~last[0];
    assign alu_rezult[1] = pv[1][2] ? pd[1][2] : ~last[1];

    // Model: a run is a time index t from the accepting edge; every output is a
    // closed-form function of t, the latency and the results computed at accept.
    always begin : model_cmp
        bit          run [2];
        int          t [2], tdone [2], mn [2];
        logic [3:0]  ma [2], mb [2];
        logic        mch [2];
        logic [1:0]  mop [2][4];
        logic [3:0]  mres [2][4];
        logic [15:0] mbus [2];
        logic [3:0]  av, ea, eb;
        logic [1:0]  eop;
        logic        een;
        logic [15:0] ebus;
        logic [28:0] expv, actv;
        int          k, ph, m, lat;

        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            lat = lat_of(i);
            if (!reset_n) begin
                run[i]  = 1'b0;
                mbus[i] = 16'h0;
            end else if (run[i]) begin
                if (t[i] == tdone[i]) begin
                    run[i]  = 1'b0;
                    mbus[i] = 16'h0;
                    for (int j = 0; j < mn[i]; j++) mbus[i][4*j +: 4] = mres[i][j];
                end else begin
                    t[i]++;
                end
            end else if (start) begin
                ma[i]  = sw[3:0];
                mb[i]  = sw[7:4];
                mch[i] = chain;
                mn[i]  = int'(op_count) + 1;
                for (int j = 0; j < 4; j++) mop[i][j] = op_list[2*j +: 2];
                for (int j = 0; j < mn[i]; j++) begin
                    if (j == 0 || !chain) av = ma[i];
                    else                  av = mres[i][j-1];
                    mres[i][j] = alu_f(mop[i][j], av, mb[i]);
                end
                run[i]   = 1'b1;
                t[i]     = 1;
                tdone[i] = 1 + mn[i] * (lat + 1);
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            lat = lat_of(i);
            ea = 4'h0; eb = 4'h0; eop = 2'b00; een = 1'b0;
            if (run[i] && t[i] < tdone[i]) begin
                k  = (t[i] - 1) / (lat + 1);
                ph = (t[i] - 1) % (lat + 1);
                if (k == 0 || !mch[i]) ea = ma[i];
                else                   ea = mres[i][k-1];
                eb  = mb[i];
                eop = mop[i][k];
                een = (ph == 0);
            end
            if (run[i]) begin
                m = (t[i] - 1) / (lat + 1);
                if (m > mn[i]) m = mn[i];
                ebus = 16'h0;
                for (int j = 0; j < m; j++) ebus[4*j +: 4] = mres[i][j];
            end else begin
                ebus = mbus[i];
            end
            expv = {ea, eb, eop, een, run[i], run[i] && t[i] == tdone[i], ebus};
            actv = {alu_a[i], alu_b[i], alu_operation[i], alu_enable[i], busy[i], done[i], result_bus[i]};
            ncmp++;
            if (actv !== expv) begin
                nfail++;
                $display("FAIL cycle_model dut%0d @%0t: got %h want %h", i, $time, actv, expv);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [7:0] s, input logic [7:0] ops, input logic [1:0] cnt, input logic ch);
        sw = s; op_list = ops; op_count = cnt; chain = ch; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called in cycle c0 of a run; counts cycles until dut_l1 pulses done.
    task automatic wait_done0(input int c0, input int exp_cyc, input logic [15:0] exp_bus, input string nm);
        int c;
        c = c0;
        while (!done[0] && c < 100) begin
            @(negedge clock);
            c++;
        end
        chk({nm, "_done_cycle"}, c, exp_cyc);
        chk({nm, "_bus"}, result_bus[0], exp_bus);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy[0] || busy[1]) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("idle_wait", {busy[0], busy[1]}, 0);
        @(negedge clock);
    endtask

    task automatic run_chk(input logic [7:0] s, input logic [7:0] ops, input logic [1:0] cnt,
                           input logic ch, input int exp_cyc, input logic [15:0] exp_bus, input string nm);
        launch(s, ops, cnt, ch);
        wait_done0(1, exp_cyc, exp_bus, nm);
        wait_idle();
    endtask

    initial begin
        bit saw_done;
        reset_n = 1'b0; start = 1'b0; sw = 8'h00; op_list = 8'h00; op_count = 2'd0; chain = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_busy", busy[0], 0);
        chk("reset_bus", result_bus[0], 16'h0);
        chk("reset_enable", alu_enable[1], 0);

        // First start accepted on the very first edge with reset released.
        reset_n = 1'b1;
        launch(8'h6F, 8'h00, 2'd0, 1'b0);
        chk("single_c1_en", alu_enable[0], 1);
        chk("single_c1_a", alu_a[0], 4'hF);
        chk("single_c1_b", alu_b[0], 4'h6);
        chk("single_c1_op", alu_operation[0], 2'b00);
        chk("lat3_c1_en", alu_enable[1], 1);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clock);
            chk($sformatf("lat3_c%0d_en", c), alu_enable[1], 0);
            chk($sformatf("single_c%0d_done", c), done[0], (c == 3) ? 1 : 0);
            chk($sformatf("lat3_c%0d_done", c), done[1], (c == 5) ? 1 : 0);
        end
        chk("single_bus", result_bus[0], 16'h0005);
        chk("lat3_bus", result_bus[1], 16'h0005);
        wait_idle();

        run_chk(8'h23, 8'b11100100, 2'd3, 1'b1, 9, 16'h2235, "chain4");
        run_chk(8'h9C, 8'b11100100, 2'd3, 1'b0, 9, 16'hD835, "nochain4");
        run_chk(8'h3A, 8'b00000001, 2'd1, 1'b1, 5, 16'h00A7, "chain2");
        run_chk(8'h71, 8'b00000001, 2'd0, 1'b0, 3, 16'h000A, "sub_wrap");

        // Inputs disturbed mid-run must not alter the run or start another.
        launch(8'h23, 8'b11100100, 2'd3, 1'b1);
        @(negedge clock);
        start = 1'b1; sw = 8'hFF; op_list = 8'hFF; op_count = 2'd0; chain = 1'b0;
        @(negedge clock);
        start = 1'b0;
        wait_done0(3, 9, 16'h2235, "busy_protect");
        @(negedge clock);
        chk("busy_protect_c10", busy[0], 0);
        @(negedge clock);
        chk("busy_protect_c11", busy[0], 0);
        wait_idle();

        // Reset for two cycles mid-run.
        launch(8'h23, 8'b11100100, 2'd3, 1'b1);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_outs", {alu_a[0], alu_b[0], alu_operation[0], alu_enable[0], busy[0], done[0]}, 0);
        chk("midrst_bus", result_bus[0], 16'h0);
        chk("midrst_busy3", busy[1], 0);
        @(negedge clock);
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done[0] || done[1]) saw_done = 1'b1;
        end
        chk("midrst_no_done", saw_done, 0);
        wait_idle();

        // start held high: runs repeat every 4 cycles with one IDLE in between.
        sw = 8'h6F; op_list = 8'h00; op_count = 2'd0; chain = 1'b0; start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            chk($sformatf("cont_c%0d_en", c), alu_enable[0], (c % 4 == 1) ? 1 : 0);
            chk($sformatf("cont_c%0d_busy", c), busy[0], (c % 4 != 0) ? 1 : 0);
            if (c == 5) chk("cont_bus_cleared", result_bus[0], 16'h0);
            if (c == 7) chk("cont_bus_result", result_bus[0], 16'h0005);
        end
        start = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide ALU_LATENCY, default 1: cycles from the alu_enable cycle to the alu_rezult sample edge; legal range 1..4.
Ports (name, direction, width, meaning):
REQ-002 SHALL provide clock, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL provide reset_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL provide start, input, 1: request a run; sampled only in IDLE.
REQ-005 SHALL provide sw, input, 8: operands; sw[3:0] is A, sw[7:4] is B.
REQ-006 SHALL provide op_list, input, 8: four 2-bit operations; slot k is op_list[2k+1:2k].
REQ-007 SHALL provide op_count, input, 2: number of slots to run minus 1.
REQ-008 SHALL provide chain, input, 1: 1 means A for slot k>0 is result[k-1].
REQ-009 SHALL provide alu_rezult, input, 4: result from the CPU datapath.
REQ-010 SHALL provide alu_a and alu_b, output, 4 each: operands to the datapath.
REQ-011 SHALL provide alu_operation, output, 2, and alu_enable, output, 1: datapath op select and issue strobe.
REQ-012 SHALL provide result_bus, output, 16: {result[3],result[2],result[1],result[0]}.
REQ-013 SHALL provide busy, output, 1, and done, output, 1 (single-cycle pulse).

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-015 IDLE with start=1 SHALL capture sw, op_list, op_count and chain, clear result_bus to 0, set idx=0, and go to ISSUE.
REQ-016 IDLE with start=0 SHALL hold all registers.
REQ-017 ISSUE SHALL last 1 cycle and drive alu_enable=1, alu_operation=slot[idx] and alu_b=B.
REQ-018 In ISSUE, alu_a SHALL be A when idx=0 or chain=0, and result[idx-1] otherwise.
REQ-019 ISSUE SHALL load the latency counter and go to WAIT.
REQ-020 WAIT SHALL last exactly ALU_LATENCY cycles with alu_enable=0 and alu_a, alu_b and alu_operation held.
REQ-021 At the edge ending the last WAIT cycle, alu_rezult SHALL be written to result[idx].
REQ-022 After that write: if idx==captured op_count, SHALL go to DONE; else SHALL increment idx and go to ISSUE.
REQ-023 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-024 busy SHALL be 1 in ISSUE, WAIT and DONE, and 0 in IDLE.
REQ-025 Timing: with the accepting start edge as cycle 0, slot k ISSUE SHALL be cycle 1+k*(ALU_LATENCY+1) and done SHALL be cycle 1+N*(ALU_LATENCY+1), where N=op_count+1.
REQ-026 result_bus SHALL be valid from the DONE cycle and held until the next accepted start.
REQ-027 Changes to start, sw, op_list, op_count or chain while busy SHALL be ignored and SHALL have no effect on the run.
REQ-028 All slot arithmetic SHALL be 4-bit; no carry or overflow is stored.
REQ-029 idx SHALL never exceed 3; op_count=3 SHALL run all four slots.
REQ-030 start held high continuously SHALL begin a new run in the cycle after DONE's IDLE cycle; there SHALL be no back-to-back issue without an IDLE cycle.
REQ-031 alu_enable SHALL never be 1 outside ISSUE.

Reset
REQ-032 reset_n=0 at a rising edge SHALL force IDLE from any state, including mid-run.
REQ-033 reset_n=0 SHALL clear idx, the latency counter, the captured operands, op_list, op_count, chain and result_bus to 0.
REQ-034 reset_n=0 SHALL drive alu_a, alu_b, alu_operation, alu_enable, busy and done to 0.
REQ-035 A run interrupted by reset SHALL produce no done pulse.
REQ-036 The first start SHALL be accepted at the first edge with reset_n=1.

Verification
Bench ALU model: 00 A+B mod 16, 01 A-B mod 16, 10 A&B, 11 A|B, with ALU_LATENCY-cycle response.
REQ-037 Reset: hold reset_n=0 for 2 cycles mid-run -> all outputs 0, busy=0, no done.
REQ-038 Single op, L=1: sw=8'h6F, op_list=8'h00, op_count=0 -> cycle 1 alu_enable=1, op=00, a=F, b=6; cycle 3 done=1; result_bus=16'h0005.
REQ-039 Chain, L=1: sw=8'h23, op_list=8'b11100100, op_count=3, chain=1 -> results 5,3,2,2; result_bus=16'h2235; done at cycle 9.
REQ-040 Latency: ALU_LATENCY=3, one op -> alu_enable only in cycle 1, sample at the end of cycle 4, done at cycle 5.
REQ-041 Busy protection: pulse start and change sw in cycle 2 of a run -> the run result is unchanged and no second run starts.
REQ-042 Continuous start: hold start=1 -> consecutive runs are separated by exactly one IDLE cycle, and result_bus clears at each accept.
